// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
// Round-robin arbiter that shares one downstream resource among N requesters.
// A registered one-hot grant is issued one cycle after a request is seen.
// Priority rotates after every grant, starting the search just after the
// most recent owner. An owner that keeps requesting for MAX_HOLD consecutive
// cycles while someone else is waiting is preempted.
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst      - synchronous active-high reset
//   req      - request vector, bit i = requester i wants the resource
//   gnt      - registered one-hot grant (zero when idle)
//   gnt_idx  - binary index of the current owner, 0 when no grant
//   gnt_v    - high whenever a grant is active (= |gnt)
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_v
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  // Search order: cand_idx[k] is the index examined at position k, i.e.
  // (last + 1 + k) mod N. Both operands are below N, so one conditional
  // subtraction performs the wrap.
  logic [IDX_W-1:0] cand_idx [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, last_q} + (IDX_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
    end
  endgenerate

  // While granting, the current owner is always 'last' and is masked out.
  // On release its req bit is already 0, so the same mask serves both the
  // release handoff and the timeout preemption.
  logic [N-1:0]     req_m;
  logic             found;
  logic [IDX_W-1:0] win;

  assign req_m = (state_q == GRANT) ? (req & ~gnt_q) : req;

  always_comb begin
    found = 1'b0;
    win   = '0;
    // Walk backwards so the earliest position in search order wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_m[cand_idx[k]]) begin
        found = 1'b1;
        win   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          gnt_d      = ONE_HOT0 << win;
          gnt_idx_d  = win;
          last_d     = win;
          hold_cnt_d = '0;
        end
      end

      GRANT: begin
        if (!req[gnt_idx_q]) begin
          // Owner released: hand off without a gap, or fall back to idle.
          if (found) begin
            gnt_d      = ONE_HOT0 << win;
            gnt_idx_d  = win;
            last_d     = win;
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            gnt_idx_d  = '0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          // Hold limit reached: preempt if anyone else is waiting,
          // otherwise the owner simply starts a fresh hold window.
          hold_cnt_d = '0;
          if (found) begin
            gnt_d     = ONE_HOT0 << win;
            gnt_idx_d = win;
            last_d    = win;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_q     <= IDX_W'(N - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_v   = |gnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter (N=4, MAX_HOLD=4).
// A driver applies directed and random request patterns at the falling edge
// and pushes the expected post-edge outputs into a queue; a monitor pops one
// entry after each rising edge and compares it with the DUT outputs.
module tb_rr_grant_arbiter;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_v;

  rr_grant_arbiter #(
    .N        (N),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_v   (gnt_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] idx;
    logic             v;
    logic             rst;
    logic [N-1:0]     req;
  } exp_t;

  exp_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  // Reference model: who owns the resource, for how many cycles it has
  // owned it so far, and who owned it most recently.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = N - 1;

  // First requester after 'from' in circular order, skipping 'excl'.
  function automatic int rr_pick(logic [N-1:0] r, int from, int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (from + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [N-1:0] r_req);
    int w;
    if (r_rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      w = rr_pick(r_req, m_last, -1);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_last = w;
      end
    end else if (!r_req[m_owner]) begin
      w = rr_pick(r_req, m_last, m_owner);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_last = w;
      end else begin
        m_owner = -1; m_held = 0;
      end
    end else if (m_held < MAX_HOLD) begin
      m_held++;
    end else begin
      w = rr_pick(r_req, m_last, m_owner);
      if (w >= 0) begin
        m_owner = w; m_last = w;
      end
      m_held = 1;
    end
  endtask

  // Apply one cycle of stimulus and record what must appear after the edge.
  task automatic drive(input logic r_rst, input logic [N-1:0] r_req);
    exp_t e;
    @(negedge clk);
    rst = r_rst;
    req = r_req;
    model_step(r_rst, r_req);
    e.gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.idx = (m_owner >= 0) ? IDX_W'(m_owner) : '0;
    e.v   = (m_owner >= 0);
    e.rst = r_rst;
    e.req = r_req;
    exp_q.push_back(e);
  endtask

  task automatic drive_n(input logic r_rst, input logic [N-1:0] r_req, input int n);
    for (int i = 0; i < n; i++) drive(r_rst, r_req);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cycle++;
        tests_run++;
        if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_v !== e.v) begin
          tests_failed++;
          $display("[TB] FAIL grant cyc=%0d rst=%0b req=%b got gnt=%b idx=%0d v=%0b want gnt=%b idx=%0d v=%0b",
                   cycle, e.rst, e.req, gnt, gnt_idx, gnt_v, e.gnt, e.idx, e.v);
        end else begin
          $display("[TB] cyc=%0d rst=%0b req=%b gnt=%b idx=%0d v=%0b ok",
                   cycle, e.rst, e.req, gnt, gnt_idx, gnt_v);
        end
        tests_run++;
        if (!$onehot0(gnt) || (gnt_v !== (|gnt))) begin
          tests_failed++;
          $display("[TB] FAIL invariant cyc=%0d got gnt=%b v=%0b want onehot0 and v=|gnt",
                   cycle, gnt, gnt_v);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] r;
    rst = 1'b1;
    req = '0;

    // 1. Reset with all requesting, then release: owner 0 first.
    drive_n(1'b1, 4'b1111, 2);
    drive_n(1'b0, 4'b1111, 2);

    // 2. Single request then drop.
    drive(1'b1, 4'b0000);
    drive_n(1'b0, 4'b0100, 3);
    drive_n(1'b0, 4'b0000, 2);

    // 3. Rotation under full contention.
    drive(1'b1, 4'b0000);
    drive_n(1'b0, 4'b1111, 20);

    // 4. Handoff on release, then wrap from 3 to 0.
    drive(1'b1, 4'b0000);
    drive_n(1'b0, 4'b0011, 2);
    drive_n(1'b0, 4'b0010, 2);
    drive_n(1'b0, 4'b1000, 2);
    drive_n(1'b0, 4'b1001, 1);
    drive_n(1'b0, 4'b0001, 2);
    drive_n(1'b0, 4'b0000, 2);

    // 5. Timeout without contention, then a late contender.
    drive(1'b1, 4'b0000);
    drive_n(1'b0, 4'b0001, 5);
    drive_n(1'b0, 4'b0101, 12);

    // 6. Reset mid-grant while owner 2 is holding, then restart from 0.
    drive(1'b1, 4'b0000);
    drive_n(1'b0, 4'b1111, 11);
    drive(1'b1, 4'b1111);
    drive_n(1'b0, 4'b1111, 3);

    // 7. Random requests with persistence and occasional reset.
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 63) == 0), r);
    end
    drive_n(1'b0, 4'b0000, 2);

    @(posedge clk);
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
